// File: rtl/spu_pkg.sv
// Shared types and constants for the SPU even/odd result staging pipes.
package spu_pkg;

  localparam int unsigned SPU_REG_ADDR_W = 7;
  localparam int unsigned SPU_DATA_W     = 128;
  localparam int unsigned SPU_MAX_LAT    = 7;
  localparam int unsigned SPU_LAT_W      = 3;
  localparam int unsigned SPU_AGE_W      = 3;

  typedef logic [SPU_AGE_W-1:0] age_t;

  typedef struct packed {
    logic                      valid;
    logic                      we;
    logic [SPU_REG_ADDR_W-1:0] addr;
    logic [SPU_DATA_W-1:0]     data;
    age_t                      age;
  } result_entry_t;

  function automatic age_t age_inc(input age_t a);
    return (a == '1) ? a : age_t'(a + 1'b1);
  endfunction

endpackage

// File: rtl/spu_result_pipe_if.sv
// Issue-side offer, flush, scoreboard query and writeback bundle of one result pipe.
interface spu_result_pipe_if
  import spu_pkg::*;
#(
  parameter int unsigned ADDR_W = SPU_REG_ADDR_W,
  parameter int unsigned DATA_W = SPU_DATA_W
);

  logic                       in_valid;
  logic                       in_we;
  logic [ADDR_W-1:0]          in_addr;
  logic [DATA_W-1:0]          in_data;
  logic [SPU_LAT_W-1:0]       in_lat;
  logic                       in_ready;
  logic                       flush;
  logic [SPU_AGE_W-1:0]       flush_age;
  logic [2:0][ADDR_W-1:0]     q_addr;
  logic [2:0]                 q_busy;
  logic [ADDR_W-1:0]          rt_addr;
  logic [DATA_W-1:0]          rt;
  logic                       reg_write;
  logic                       lat_err;

  modport master (
    output in_valid, in_we, in_addr, in_data, in_lat, flush, flush_age, q_addr,
    input  in_ready, q_busy, rt_addr, rt, reg_write, lat_err
  );

  modport slave (
    input  in_valid, in_we, in_addr, in_data, in_lat, flush, flush_age, q_addr,
    output in_ready, q_busy, rt_addr, rt, reg_write, lat_err
  );

endinterface

// File: rtl/spu_result_stage.sv
// One slot of the result shift pipeline: takes the upstream slot or a fresh insert, ages it, applies flush.
module spu_result_stage
  import spu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  result_entry_t shift_in,
  input  logic          ins_en,
  input  result_entry_t ins_entry,
  input  logic          flush,
  input  age_t          flush_age,
  output result_entry_t entry_q
);

  result_entry_t entry_d;
  age_t          pre_age;

  // Flush compares the age the entry had this cycle, before the shift increment.
  always_comb begin
    entry_d     = shift_in;
    entry_d.age = age_inc(shift_in.age);
    pre_age     = shift_in.age;
    if (ins_en) begin
      entry_d = ins_entry;
      pre_age = '0;
    end
    if (flush && (pre_age < flush_age)) begin
      entry_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

endmodule

// File: rtl/spu_result_pipe.sv
// Per-pipe result staging and writeback scheduler feeding one register-file write port.
module spu_result_pipe
  import spu_pkg::*;
#(
  parameter int unsigned DEPTH  = SPU_MAX_LAT,
  parameter int unsigned ADDR_W = SPU_REG_ADDR_W,
  parameter int unsigned DATA_W = SPU_DATA_W
) (
  input logic              clk,
  input logic              reset,
  spu_result_pipe_if.slave bus
);

  result_entry_t s_q      [DEPTH];
  result_entry_t shift_in [DEPTH];
  result_entry_t ins_entry;
  logic          lat_legal;
  logic          slot_taken;
  logic          accept;
  logic          lat_err_d;
  logic          lat_err_q;

  // s[L] shifts into s[L-1] this edge, so a valid s[L] means the writeback slot is already owned.
  always_comb begin
    lat_legal  = (bus.in_lat != '0) && (32'(bus.in_lat) <= DEPTH);
    slot_taken = 1'b0;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      if ((32'(bus.in_lat) == k) && s_q[k].valid) slot_taken = 1'b1;
    end
    bus.in_ready = !(lat_legal && slot_taken);
    accept       = bus.in_valid && lat_legal && bus.in_ready;
    lat_err_d    = lat_err_q || (bus.in_valid && !lat_legal);

    ins_entry       = '0;
    ins_entry.valid = 1'b1;
    ins_entry.we    = bus.in_we;
    ins_entry.addr  = bus.in_addr;
    ins_entry.data  = bus.in_data;
  end

  always_comb begin
    bus.q_busy = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (s_q[k].valid && s_q[k].we && (s_q[k].addr == bus.q_addr[i])) bus.q_busy[i] = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == DEPTH - 1) begin : g_tail
      assign shift_in[k] = '0;
    end else begin : g_body
      assign shift_in[k] = s_q[k+1];
    end

    spu_result_stage u_stage (
      .clk       (clk),
      .reset     (reset),
      .shift_in  (shift_in[k]),
      .ins_en    (accept && (32'(bus.in_lat) == k + 1)),
      .ins_entry (ins_entry),
      .flush     (bus.flush),
      .flush_age (bus.flush_age),
      .entry_q   (s_q[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lat_err_q <= 1'b0;
    end else begin
      lat_err_q <= lat_err_d;
    end
  end

  assign bus.reg_write = s_q[0].valid && s_q[0].we;
  assign bus.rt_addr   = ADDR_W'(s_q[0].addr);
  assign bus.rt        = DATA_W'(s_q[0].data);
  assign bus.lat_err   = lat_err_q;

endmodule
